// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the THR write decode / transmit FSM and the
// transmit holding FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  thr_wr;
    logic [DATA_WIDTH-1:0] thr_wdata;
    logic                  fifo_en;
    logic                  tx_fifo_rst;
    logic                  tsr_load;
    logic                  tsr_empty;
    logic [DATA_WIDTH-1:0] tsr_data;
    logic                  thre;
    logic                  temt;
    logic                  tx_full;
    logic [ADDR_WIDTH:0]   tx_count;
    logic                  thre_int;
    logic                  wr_drop;

    modport master (
        output thr_wr, thr_wdata, fifo_en, tx_fifo_rst, tsr_load, tsr_empty,
        input  tsr_data, thre, temt, tx_full, tx_count, thre_int, wr_drop
    );

    modport slave (
        input  thr_wr, thr_wdata, fifo_en, tx_fifo_rst, tsr_load, tsr_empty,
        output tsr_data, thre, temt, tx_full, tx_count, thre_int, wr_drop
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit holding buffer: first-word-fall-through queue of DEPTH
// bytes in FIFO mode, single holding register otherwise.
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic           pclk,
    input  logic           presetn,
    uart_tx_fifo_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] CAP_FIFO = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CAP_ONE  = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  fen_q;
    logic                  thre_int_q, wr_drop_q;

    logic [ADDR_WIDTH:0]   cap;
    logic                  empty, full, pop_ok, wr_ok, flush;

    assign cap    = bus.fifo_en ? CAP_FIFO : CAP_ONE;
    assign empty  = (count == '0);
    assign full   = (count == cap);
    assign pop_ok = bus.tsr_load & ~empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign wr_ok  = bus.thr_wr & (~full | pop_ok);
    // Any mode change invalidates the queue contents.
    assign flush  = bus.tx_fifo_rst | (bus.fifo_en != fen_q);

    assign bus.tsr_data = empty ? '0 : mem[rd_ptr];
    assign bus.thre     = empty;
    assign bus.temt     = empty & bus.tsr_empty;
    assign bus.tx_full  = full;
    assign bus.tx_count = count;
    assign bus.thre_int = thre_int_q;
    assign bus.wr_drop  = wr_drop_q;

    // Storage array: written on accepted writes, never reset.
    always_ff @(posedge pclk) begin
        if (wr_ok && !flush) mem[wr_ptr] <= bus.thr_wdata;
    end

    // Pointers, occupancy, mode copy and status pulses.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fen_q      <= 1'b0;
            thre_int_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            fen_q      <= bus.fifo_en;
            wr_drop_q  <= bus.thr_wr & (flush | ~wr_ok);
            thre_int_q <= ~flush & pop_ok & ~wr_ok & (count == CAP_ONE);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
                case ({wr_ok, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a byte-queue scoreboard.
module tb_uart_tx_fifo;
    logic pclk = 1'b0;
    logic presetn;

    uart_tx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    uart_tx_fifo #(.DEPTH(16), .DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    logic       m_fen_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; inputs are applied just after a rising
    // edge and outputs are checked just after the next one.
    task automatic cyc(input logic wr, input logic [7:0] d, input logic ld,
                       input logic frst, input logic fen, input string tag);
        int   cap;
        logic pop, full, wacc, flush, e_drop, e_int;
        bus.thr_wr      = wr;
        bus.thr_wdata   = d;
        bus.tsr_load    = ld;
        bus.tx_fifo_rst = frst;
        bus.fifo_en     = fen;
        cap   = fen ? 16 : 1;
        flush = frst || (fen != m_fen_q);
        pop   = ld && (sb.size() > 0);
        full  = (sb.size() == cap);
        wacc  = wr && (!full || pop);
        if (pop) chk({tag, "_head"}, bus.tsr_data, sb[0]);
        e_int = 1'b0;
        if (flush) begin
            sb.delete();
            e_drop = wr;
        end else begin
            if (pop) void'(sb.pop_front());
            if (wacc) sb.push_back(d);
            e_drop = wr && !wacc;
            e_int  = pop && !wacc && (sb.size() == 0);
        end
        m_fen_q = fen;
        @(posedge pclk);
        #1;
        bus.thr_wr      = 1'b0;
        bus.tsr_load    = 1'b0;
        bus.tx_fifo_rst = 1'b0;
        chk({tag, "_drop"},  bus.wr_drop,  e_drop);
        chk({tag, "_int"},   bus.thre_int, e_int);
        chk({tag, "_count"}, bus.tx_count, sb.size());
        chk({tag, "_thre"},  bus.thre,     sb.size() == 0);
        chk({tag, "_full"},  bus.tx_full,  sb.size() == cap);
        chk({tag, "_data"},  bus.tsr_data, (sb.size() > 0) ? sb[0] : 8'h00);
        chk({tag, "_temt"},  bus.temt,     (sb.size() == 0) && bus.tsr_empty);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_thre"},  bus.thre,     1);
        chk({tag, "_count"}, bus.tx_count, 0);
        chk({tag, "_data"},  bus.tsr_data, 0);
        chk({tag, "_full"},  bus.tx_full,  0);
        chk({tag, "_int"},   bus.thre_int, 0);
        chk({tag, "_drop"},  bus.wr_drop,  0);
    endtask

    initial begin
        presetn         = 1'b0;
        bus.thr_wr      = 1'b0;
        bus.thr_wdata   = 8'h00;
        bus.fifo_en     = 1'b0;
        bus.tx_fifo_rst = 1'b0;
        bus.tsr_load    = 1'b0;
        bus.tsr_empty   = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        chk_reset_outputs("rst");
        chk("rst_temt", bus.temt, 1);
        presetn = 1'b1;
        @(posedge pclk);
        #1;

        // Pop strobe on an empty queue is ignored.
        cyc(0, 8'h00, 1, 0, 0, "empty_ld");

        // FIFO mode: fill, overflow, drain.
        cyc(0, 8'h00, 0, 0, 1, "mode_fifo");
        for (int i = 0; i < 16; i++) cyc(1, 8'h11 + 8'(i), 0, 0, 1, "fill");
        chk("full_flag", bus.tx_full, 1);
        chk("full_cnt",  bus.tx_count, 16);
        cyc(1, 8'h55, 0, 0, 1, "ovf");
        chk("ovf_drop", bus.wr_drop, 1);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 1, "drain");

        // Full queue with simultaneous write and pop; 0xAA becomes the tail.
        for (int i = 0; i < 16; i++) cyc(1, 8'h30 + 8'(i), 0, 0, 1, "fill2");
        cyc(1, 8'hAA, 1, 0, 1, "full_wrpop");
        chk("full_wrpop_cnt", bus.tx_count, 16);
        for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0, 1, "drain2");
        chk("aa_last", bus.tsr_data, 8'hAA);
        cyc(0, 8'h00, 1, 0, 1, "drain2_last");

        // Three more full laps with interleaved streaming to wrap pointers.
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < 16; i++) cyc(1, 8'(lap * 40 + i * 3 + 1), 0, 0, 1, "lap_fill");
            for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + lap * 4 + i), 1, 0, 1, "lap_stream");
            for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 1, "lap_drain");
        end

        // Single-entry mode.
        cyc(0, 8'h00, 0, 0, 0, "mode_one");
        cyc(1, 8'h3C, 0, 0, 0, "one_wr");
        chk("one_full", bus.tx_full, 1);
        cyc(1, 8'h4D, 0, 0, 0, "one_drop");
        chk("one_drop_pulse", bus.wr_drop, 1);
        cyc(1, 8'h5E, 1, 0, 0, "one_replace");
        chk("one_replace_data", bus.tsr_data, 8'h5E);
        chk("one_replace_thre", bus.thre, 0);
        cyc(0, 8'h00, 1, 0, 0, "one_pop");

        // Flush by FCR reset pulse coincident with a write.
        cyc(0, 8'h00, 0, 0, 1, "mode_fifo2");
        for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0, 0, 1, "pre_flush");
        cyc(1, 8'h77, 0, 1, 1, "flush_rst");
        chk("flush_rst_drop", bus.wr_drop, 1);
        chk("flush_rst_cnt",  bus.tx_count, 0);
        cyc(0, 8'h00, 0, 0, 1, "post_flush");

        // Flush by mode toggle coincident with a write.
        for (int i = 0; i < 5; i++) cyc(1, 8'h68 + 8'(i), 0, 0, 1, "pre_tog");
        cyc(1, 8'h88, 0, 0, 0, "flush_tog");
        chk("flush_tog_drop", bus.wr_drop, 1);
        chk("flush_tog_thre", bus.thre, 1);
        cyc(0, 8'h00, 0, 0, 0, "post_tog");

        // Asynchronous reset mid-operation.
        cyc(0, 8'h00, 0, 0, 1, "mode_fifo3");
        for (int i = 0; i < 7; i++) cyc(1, 8'h90 + 8'(i), 0, 0, 1, "pre_arst");
        chk("pre_arst_cnt", bus.tx_count, 7);
        #2;
        presetn = 1'b0;
        #1;
        sb.delete();
        m_fen_q = 1'b0;
        chk_reset_outputs("arst");
        bus.tsr_empty = 1'b0;
        #1;
        chk("arst_temt0", bus.temt, 0);
        bus.tsr_empty = 1'b1;
        #1;
        chk("arst_temt1", bus.temt, 1);
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        cyc(0, 8'h00, 0, 0, 1, "post_arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit holding buffer for the UART, placed between the APB register interface and the transmit FSM. Accepts bytes written to THR, holds them in a first-word-fall-through queue, presents the head byte to the transmit shift register, and produces the `thre` status consumed by the transmit FSM. In FIFO mode it is DEPTH entries deep. In non-FIFO mode it behaves as a single-entry holding register.

## Interface
- `DEPTH`, 16, number of entries in FIFO mode; power of two, ≥ 2
- `DATA_WIDTH`, 8, byte width
- `ADDR_WIDTH`, $clog2(DEPTH), pointer width

Ports:
- `pclk` in 1: single clock
- `presetn` in 1: asynchronous, active-low reset
- `thr_wr` in 1: single-cycle write strobe for THR (APB write decode)
- `thr_wdata` in DATA_WIDTH: byte to enqueue
- `fifo_en` in 1: FCR[0]; 1 selects FIFO mode, 0 selects single-entry mode
- `tx_fifo_rst` in 1: FCR[2] self-clearing pulse; flushes the queue
- `tsr_load` in 1: pop strobe from the transmit FSM
- `tsr_empty` in 1: transmit shift register idle, from the transmit datapath
- `tsr_data` out DATA_WIDTH: head byte; 0 when empty
- `thre` out 1: queue empty
- `temt` out 1: `thre & tsr_empty`
- `tx_full` out 1: queue at effective depth
- `tx_count` out ADDR_WIDTH+1: number of occupied entries
- `thre_int` out 1: one-cycle pulse when a pop empties the queue
- `wr_drop` out 1: one-cycle pulse when a write is discarded

## Operation
- Storage: DEPTH×DATA_WIDTH array with no reset. Write pointer and read pointer are each ADDR_WIDTH bits and wrap naturally from DEPTH−1 to 0. `count` is a separate register of ADDR_WIDTH+1 bits.
- Effective depth: `cap = fifo_en ? DEPTH : 1`.
- `tx_full = (count == cap)`. `thre = (count == 0)`. Both flags decode only from registered count.
- `tsr_data = thre ? 0 : mem[rd_ptr]`. This is combinational, so the transmit FSM captures the head byte in the same cycle it asserts `tsr_load`.
- Write accepted when `thr_wr & (~tx_full | pop_ok)`. On accept: store to `mem[wr_ptr]`, then increment `wr_ptr`.
- `pop_ok = tsr_load & ~thre`. On pop: increment `rd_ptr`. A `tsr_load` while empty is ignored and leaves all state unchanged.
- Simultaneous accepted write and valid pop: both pointers advance and `count` is unchanged. This includes the full case, where the write lands in the slot freed that cycle.
- `thr_wr` while full with no pop: data discarded, state unchanged, `wr_drop` pulses on the next cycle.
- Flush sources: `tx_fifo_rst` high, or `fifo_en` differing from its registered copy (any mode change).
  - Flush sets both pointers and `count` to 0.
  - Flush has priority: a write or pop in the same cycle is discarded.
  - `wr_drop` pulses if a write was discarded by the flush.
  - `thre_int` does not pulse on flush.
- `thre_int` pulses for one cycle after the edge at which a pop (with no simultaneous write) took `count` from 1 to 0.
- Non-FIFO mode with `count` = 1 and a write plus pop in the same cycle: the new byte replaces the head and `thre` stays low.

## Timing
- Reset values (async on `presetn` low): pointers 0, `count` 0, `fifo_en` copy 0.
  - Outputs: `thre` 1, `tx_full` 0, `tx_count` 0, `tsr_data` 0, `thre_int` 0, `wr_drop` 0.
  - `temt` follows `tsr_empty`.
- Write at edge N: `thre` falls and `tsr_data` shows the byte after edge N. The write-to-head latency is 1 cycle.
- Pop at edge N: `tsr_data` advances to the next byte after edge N. There is no bubble between back-to-back pops.
- `thre_int` and `wr_drop` are registered, asserted in the cycle after the causing edge, and last exactly one cycle.
- Reset asserted mid-operation clears all state immediately. Array contents are retained but unreachable.
- Throughput: one write and one pop per cycle, sustained.

## Test plan
- Reset → `thre`=1, `tx_count`=0, `tsr_data`=0, `tx_full`=0. Then `tsr_load` with the queue empty → no state change.
- `fifo_en`=1; write 0x11..0x20 (16 bytes) → `tx_full`=1, `tx_count`=16. A 17th write of 0x55 → `wr_drop` pulse, `tx_count` stays 16. Then 16 pops → `tsr_data` sequence 0x11..0x20. `thre_int` pulses once after the last pop.
- Full queue with a simultaneous write of 0xAA and a pop → `tx_count` stays 16, 0xAA emerges as the 16th byte. Pointers wrap correctly over 3 full cycles.
- `fifo_en`=0; write 0x3C → `tx_full`=1. Write 0x4D with no pop → dropped. Write 0x5E with a pop → `tsr_data`=0x5E.
- Queue holding 5 bytes plus a `tx_fifo_rst` pulse coincident with a write → `tx_count`=0, `thre`=1, `wr_drop` pulse, no `thre_int`. Repeat with a `fifo_en` toggle instead of `tx_fifo_rst` → same result.
- `presetn` low while `tx_count`=7 → all outputs return to reset values within the same cycle. `temt`=1 only when `tsr_empty`=1.
